// File: rtl/truth_table_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_t          : sweep FSM states
//   NUM_VECTORS      : number of input combinations of a 3-input circuit
//   IDX_W            : width of the vector index (drives abc directly)
//   CNT_W            : width of the settle counter (SETTLE_CYCLES 0..15)
//   lowest_mismatch(): index of the lowest differing bit, 0 when equal
package truth_table_sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Scans from the top down so the last hit is the lowest index.
    function automatic logic [IDX_W-1:0] lowest_mismatch(
        input logic [NUM_VECTORS-1:0] a,
        input logic [NUM_VECTORS-1:0] b
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (a[i] != b[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweep.sv
// Walks a 3-input combinational circuit through all 8 input vectors, waits
// SETTLE_CYCLES+1 cycles per vector for the output to settle, samples it,
// and compares the captured truth table against a golden table.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request a sweep (only looked at in IDLE)
//   expected    : golden truth table, latched when the sweep is accepted
//   y_in        : output of the circuit under test
//   abc         : drive to the circuit under test (abc[2]=A .. abc[0]=C)
//   busy        : high while settling/sampling
//   done        : one-cycle pulse when the sweep completes
//   truth       : captured truth table, held in IDLE
//   pass        : captured table matches the latched golden table
//   first_fail  : lowest mismatching vector, 0 on pass
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   y_in,
    output logic [IDX_W-1:0]       abc,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth,
    output logic                   pass,
    output logic [IDX_W-1:0]       first_fail
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_VECTORS-1:0]  exp_q;
    logic [NUM_VECTORS-1:0]  truth_nxt;

    // The index register is the circuit drive; it only moves on SAMPLE, so
    // abc is stable across each vector's settle and sample cycles.
    assign abc = idx;

    // Table including the bit being sampled this cycle, so the final compare
    // on entry to DONE sees vector 7.
    always_comb begin
        truth_nxt      = truth;
        truth_nxt[idx] = y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            exp_q      <= '0;
            truth      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q      <= expected;
                        truth      <= '0;
                        idx        <= '0;
                        cnt        <= SETTLE_LD;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        first_fail <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter runs SETTLE_CYCLES..0, giving SETTLE_CYCLES+1 cycles.
                    if (cnt == '0) state <= ST_SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    truth <= truth_nxt;
                    if (idx == LAST_IDX) begin
                        // idx stays at 7 so abc holds until the next start.
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (truth_nxt == exp_q);
                        first_fail <= lowest_mismatch(truth_nxt, exp_q);
                        state      <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        cnt   <= SETTLE_LD;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, start0 = 1'b0;
    logic [7:0] exp2 = 8'h00, exp0 = 8'h00;

    logic [2:0] abc2, abc0, ff2, ff0;
    logic       busy2, busy0, done2, done0, pass2, pass0;
    logic [7:0] truth2, truth0;
    logic       y2, y0;

    // Circuit under test: Y = (A+B+C)(A+B)(A+C) = A + BC -> table 8'hF8
    assign y2 = abc2[2] | (abc2[1] & abc2[0]);
    assign y0 = abc0[2] | (abc0[1] & abc0[0]);

    truth_table_sweep #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2), .y_in(y2),
        .abc(abc2), .busy(busy2), .done(done2), .truth(truth2), .pass(pass2),
        .first_fail(ff2)
    );

    truth_table_sweep #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .y_in(y0),
        .abc(abc0), .busy(busy0), .done(done0), .truth(truth0), .pass(pass0),
        .first_fail(ff0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic get(input bit sel, output logic b, output logic d, output logic [2:0] a);
        if (sel) begin b = busy0; d = done0; a = abc0; end
        else     begin b = busy2; d = done2; a = abc2; end
    endtask

    // Issues start, then samples #1 after each edge until done. done_edge
    // counts the accepting edge as edge 1; 0 means done never came.
    task automatic sweep(input bit sel, input logic [7:0] e, input bit disturb,
                         output int done_edge, output int busy_cyc, output bit abc_ok);
        int per;
        logic b, d;
        logic [2:0] a;
        per = sel ? 2 : 4;
        if (sel) begin start0 = 1'b1; exp0 = e; end
        else     begin start2 = 1'b1; exp2 = e; end
        @(posedge clk); #1;
        start0 = 1'b0; start2 = 1'b0;
        done_edge = 0; busy_cyc = 0; abc_ok = 1'b1;
        for (int j = 0; j < 200; j++) begin
            get(sel, b, d, a);
            if (d) begin done_edge = j + 1; break; end
            if (b) busy_cyc++;
            if (a != 3'(j / per)) abc_ok = 1'b0;
            if (disturb && j == 10) begin start2 = 1'b1; exp2 = 8'h00; end
            if (disturb && j == 11) start2 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done2(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done2) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int de, bc, idle;
        bit ok, seen;

        // Reset state
        @(posedge clk); #1;
        chk("rst_outs2", {abc2, busy2, done2, truth2, pass2, ff2}, 32'd0);
        chk("rst_outs0", {abc0, busy0, done0, truth0, pass0, ff0}, 32'd0);
        rst_n = 1'b1;

        // Basic sweep, accepted on the first edge after reset release
        sweep(1'b0, 8'hF8, 1'b0, de, bc, ok);
        chk("f8_done_edge", de, 33);
        chk("f8_busy_cyc", bc, 32);
        chk("f8_abc_seq", ok, 1);
        chk("f8_truth", truth2, 8'hF8);
        chk("f8_pass", pass2, 1);
        chk("f8_ff", ff2, 0);
        chk("f8_busy_in_done", busy2, 0);
        @(posedge clk); #1;
        chk("idle_abc_hold", abc2, 3'd7);
        chk("idle_truth_hold", truth2, 8'hF8);
        chk("idle_pass_hold", pass2, 1);
        chk("idle_done_low", done2, 0);

        // Mismatching golden table
        sweep(1'b0, 8'hF0, 1'b0, de, bc, ok);
        chk("f0_done_edge", de, 33);
        chk("f0_truth", truth2, 8'hF8);
        chk("f0_pass", pass2, 0);
        chk("f0_ff", ff2, 3);
        @(posedge clk); #1;

        // start pulse and expected change mid-sweep
        sweep(1'b0, 8'hF8, 1'b1, de, bc, ok);
        chk("dist_done_edge", de, 33);
        chk("dist_abc_seq", ok, 1);
        chk("dist_pass", pass2, 1);
        chk("dist_ff", ff2, 0);
        @(posedge clk); #1;

        // start held high: one IDLE cycle between done and next busy
        exp2 = 8'hF8; start2 = 1'b1;
        wait_done2(seen);
        chk("b2b_done1", seen, 1);
        idle = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (busy2) break;
            idle++;
        end
        chk("b2b_idle_cycles", idle, 1);
        start2 = 1'b0;
        wait_done2(seen);
        chk("b2b_done2", seen, 1);
        chk("b2b_pass", pass2, 1);
        @(posedge clk); #1;

        // Zero settle cycles
        sweep(1'b1, 8'hF8, 1'b0, de, bc, ok);
        chk("s0_done_edge", de, 17);
        chk("s0_busy_cyc", bc, 16);
        chk("s0_abc_seq", ok, 1);
        chk("s0_truth", truth0, 8'hF8);
        chk("s0_pass", pass0, 1);

        // Reset mid-sweep at vector 5
        exp2 = 8'hF8; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (abc2 == 3'd5) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("mid_reached_v5", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {abc2, busy2, done2, truth2, pass2, ff2}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done2) seen = 1'b1;
        end
        chk("mid_no_done", seen, 0);
        chk("mid_truth_clear", truth2, 8'h00);
        rst_n = 1'b1;
        sweep(1'b0, 8'hF8, 1'b0, de, bc, ok);
        chk("post_rst_done_edge", de, 33);
        chk("post_rst_truth", truth2, 8'hF8);
        chk("post_rst_pass", pass2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, setting the number of extra settle cycles per vector (legal range 0..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-005 SHALL have port expected, input, 8 bits: golden truth table; bit i is the expected y for vector i.
REQ-006 SHALL have port y_in, input, 1 bit: output of the 3-input circuit under test.
REQ-007 SHALL have port abc, output, 3 bits: drives the DUT; abc[2]=A, abc[1]=B, abc[0]=C.
REQ-008 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-010 SHALL have port truth, output, 8 bits: captured truth table.
REQ-011 SHALL have port pass, output, 1 bit: captured table equals the latched expected value.
REQ-012 SHALL have port first_fail, output, 3 bits: lowest mismatching vector index; 0 when pass=1.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 IDLE with start=1 SHALL, on that edge: latch expected, clear truth, set idx=0 and abc=0, load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-015 SETTLE SHALL decrement the counter each cycle and enter SAMPLE on the cycle the counter equals 0; SETTLE therefore lasts SETTLE_CYCLES+1 cycles.
REQ-016 SAMPLE SHALL write y_in into truth[idx].
REQ-017 In SAMPLE, if idx<7, the block SHALL increment idx, set abc to the new idx, reload the counter, and enter SETTLE.
REQ-018 In SAMPLE, if idx==7, the block SHALL enter DONE.
REQ-019 Each vector SHALL take exactly SETTLE_CYCLES+2 cycles; abc SHALL be stable throughout SETTLE and SAMPLE.
REQ-020 DONE SHALL last one cycle, with done=1 and busy=0, and SHALL return to IDLE unconditionally.
REQ-021 pass and first_fail SHALL update on the edge entering DONE and SHALL hold until the next accepted start.
REQ-022 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-023 start SHALL be ignored when not in IDLE, including during the DONE cycle.
REQ-024 A change on expected after start is accepted SHALL NOT affect the result.
REQ-025 With start held high continuously, back-to-back sweeps SHALL run with exactly one IDLE cycle between them.
REQ-026 idx SHALL NOT wrap past 7 within a sweep; abc SHALL hold 3'd7 after the sweep until the next start.
REQ-027 truth SHALL keep its last-captured value in IDLE.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with abc=0, busy=0, done=0, truth=0, pass=0, first_fail=0, idx=0 and counter=0.
REQ-029 Reset asserted mid-sweep SHALL abort immediately with no done pulse; no stale truth bits SHALL remain.
REQ-030 The block SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the state enum, NUM_VECTORS=8 and the vector-index width of 3.
REQ-032 The block SHALL be a single module with no sub-module; the DUT is instantiated only by the bench.

Verification
REQ-033 Bench SHALL connect the POS circuit Y=(A+B+C)(A+B)(A+C), pulse start with expected=8'hF8 and SETTLE_CYCLES=2 -> truth=8'hF8, pass=1, first_fail=0, and done on the 33rd edge after start is accepted.
REQ-034 Same setup with expected=8'hF0 -> pass=0, first_fail=3, truth=8'hF8.
REQ-035 Bench SHALL check abc sequence 0..7, each value held exactly 4 cycles, and busy high for exactly 32 cycles.
REQ-036 Bench SHALL assert rst_n low at vector 5 -> all outputs 0 immediately, no done pulse; a following sweep SHALL return truth=8'hF8.
REQ-037 Bench SHALL pulse start while busy, and change expected mid-sweep -> no restart, result unchanged; with start held high -> exactly one IDLE cycle between done and the next busy.
REQ-038 Bench SHALL run SETTLE_CYCLES=0 -> 2 cycles per vector, done on the 17th edge, truth=8'hF8.
